// File: rtl/rr_decoder_arbiter_if.sv
// Request/grant bundle between up to four requesters and the round-robin arbiter.
// The master drives requests and release; the slave (arbiter) returns grant status.
interface rr_decoder_arbiter_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       busy;
  logic       timeout;

  modport master (
    output req, done,
    input  grant, grant_idx, busy, timeout
  );

  modport slave (
    input  req, done,
    output grant, grant_idx, busy, timeout
  );
endinterface

// File: rtl/rr_decoder_arbiter.sv
// Four-requester round-robin arbiter with hold timeout.
// The winner is kept as a 2-bit index and decoded to a one-hot grant while in GRANT.
module rr_decoder_arbiter #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  rr_decoder_arbiter_if.slave  bus
);

  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_idx,   w_idx_nxt;
  logic [1:0]       r_ptr,   w_ptr_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
  logic             r_timeout, w_timeout_nxt;

  logic [3:0]       w_rot;
  logic [1:0]       w_offset;
  logic [1:0]       w_winner;
  logic             w_found;
  logic             w_owner_req;
  logic             w_expired;

  function automatic logic [1:0] add2(input logic [1:0] a, input logic [1:0] b);
    return a + b;
  endfunction

  // Requests rotated so that bit 0 is the requester at ptr; first set bit wins.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_rot[k] = bus.req[add2(r_ptr, 2'(k))];
    end
    if      (w_rot[0]) w_offset = 2'd0;
    else if (w_rot[1]) w_offset = 2'd1;
    else if (w_rot[2]) w_offset = 2'd2;
    else               w_offset = 2'd3;
    w_winner = add2(r_ptr, w_offset);
    w_found  = |bus.req;
  end

  assign w_owner_req = bus.req[r_idx];
  assign w_expired   = (TIMEOUT != 0) && (r_cnt == TIMEOUT_C);

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_idx     <= 2'd0;
      r_ptr     <= 2'd0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_GRANT;
          w_idx_nxt   = w_winner;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      ST_GRANT: begin
        if (bus.done || !w_owner_req || w_expired) begin
          // A done in the expiry cycle is an ordinary release, so no timeout pulse.
          w_state_nxt   = ST_IDLE;
          w_ptr_nxt     = add2(r_idx, 2'd1);
          w_cnt_nxt     = '0;
          w_timeout_nxt = w_expired && !bus.done && w_owner_req;
        end else if (r_cnt != CNT_MAX) begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs depend only on registers, so they change only at clock edges.
  always_comb begin
    bus.grant     = (r_state == ST_GRANT) ? (4'b0001 << r_idx) : 4'b0000;
    bus.grant_idx = r_idx;
    bus.busy      = (r_state == ST_GRANT);
    bus.timeout   = r_timeout;
  end

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Directed bench for rr_decoder_arbiter: an integer-level arbitration model checked every
// cycle, plus literal expectations for each test scenario.
module tb_rr_decoder_arbiter;
  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  rr_decoder_arbiter_if bus ();

  rr_decoder_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: who owns the resource, for how long, and where the scan starts next.
  bit m_valid = 0;
  bit m_busy;
  int m_owner, m_ptr, m_hold;
  bit m_to;

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1; m_busy = 0; m_owner = 0; m_ptr = 0; m_hold = 0; m_to = 0;
    end else if (m_valid) begin
      m_to = 0;
      if (!m_busy) begin
        for (int k = 3; k >= 0; k--)
          if (bus.req[(m_ptr + k) % 4]) begin m_owner = (m_ptr + k) % 4; m_busy = 1; end
        if (m_busy) m_hold = 1;
      end else begin
        if (bus.done || !bus.req[m_owner] || (TIMEOUT != 0 && m_hold == TIMEOUT)) begin
          m_to   = !bus.done && bus.req[m_owner];
          m_busy = 0;
          m_ptr  = (m_owner + 1) % 4;
          m_hold = 0;
        end else if (m_hold < 2**CNT_W - 1) begin
          m_hold++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model.grant",   bus.grant, m_busy ? 4'(1 << m_owner) : 4'b0000);
      check("model.idx",     {2'b00, bus.grant_idx}, 4'(m_owner));
      check("model.busy",    {3'b000, bus.busy}, {3'b000, m_busy});
      check("model.timeout", {3'b000, bus.timeout}, {3'b000, m_to});
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; bus.req = 4'b0000; bus.done = 1'b0;
    cyc(2);
    reset = 1'b0;
  endtask

  localparam int NV = 14;
  logic [3:0] v_req  [NV] = '{4'b1111, 4'b1110, 4'b1100, 4'b1100, 4'b0000, 4'b1001, 4'b1001,
                              4'b1001, 4'b0000, 4'b0000, 4'b0110, 4'b0110, 4'b0110, 4'b0110};
  logic       v_done [NV] = '{0, 0, 0, 1, 1, 0, 1, 0, 0, 1, 0, 0, 1, 0};
  logic [3:0] t3_exp [5]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    reset = 1'b1; bus.req = 4'b0000; bus.done = 1'b0;
    cyc(1);
    check("reset.grant", bus.grant, 4'b0000);
    check("reset.idx",   {2'b00, bus.grant_idx}, 4'b0000);
    check("reset.busy",  {3'b000, bus.busy}, 4'b0000);
    cyc(1);
    reset = 1'b0;

    // T1
    bus.req = 4'b0101;
    cyc(1);
    check("t1.grant", bus.grant, 4'b0001);
    check("t1.idx",   {2'b00, bus.grant_idx}, 4'b0000);
    check("t1.busy",  {3'b000, bus.busy}, 4'b0001);

    // T2
    bus.done = 1'b1;
    cyc(1);
    bus.done = 1'b0;
    check("t2.gap", bus.grant, 4'b0000);
    cyc(1);
    check("t2.grant", bus.grant, 4'b0100);
    check("t2.idx",   {2'b00, bus.grant_idx}, 4'b0010);

    // T3: done on every third grant cycle
    do_reset();
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      cyc(1);
      check("t3.order", bus.grant, t3_exp[g]);
      cyc(2);
      bus.done = 1'b1;
      cyc(1);
      bus.done = 1'b0;
      check("t3.gap", bus.grant, 4'b0000);
    end

    // T4: timeout after 15 held cycles
    do_reset();
    bus.req = 4'b0010;
    for (int i = 0; i < TIMEOUT; i++) begin
      cyc(1);
      check("t4.hold", bus.grant, 4'b0010);
      check("t4.no_to", {3'b000, bus.timeout}, 4'b0000);
    end
    cyc(1);
    check("t4.gap",   bus.grant, 4'b0000);
    check("t4.pulse", {3'b000, bus.timeout}, 4'b0001);
    cyc(1);
    check("t4.regrant", bus.grant, 4'b0010);
    check("t4.pulse_end", {3'b000, bus.timeout}, 4'b0000);

    // done coinciding with expiry is a normal release
    do_reset();
    bus.req = 4'b0010;
    cyc(TIMEOUT);
    bus.done = 1'b1;
    cyc(1);
    bus.done = 1'b0;
    check("tdx.gap", bus.grant, 4'b0000);
    check("tdx.no_to", {3'b000, bus.timeout}, 4'b0000);

    // T5: owner withdraws its request
    do_reset();
    bus.req = 4'b0001;
    cyc(1);
    check("t5.grant", bus.grant, 4'b0001);
    bus.req = 4'b0000;
    cyc(1);
    check("t5.drop", bus.grant, 4'b0000);
    check("t5.no_to", {3'b000, bus.timeout}, 4'b0000);

    // T6: reset mid-grant
    bus.req = 4'b0100;
    cyc(1);
    check("t6.grant", bus.grant, 4'b0100);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check("t6.rst_grant", bus.grant, 4'b0000);
    check("t6.rst_idx",   {2'b00, bus.grant_idx}, 4'b0000);
    bus.req = 4'b1000;
    cyc(1);
    check("t6.grant2", bus.grant, 4'b1000);
    check("t6.idx2",   {2'b00, bus.grant_idx}, 4'b0011);

    // Mixed directed vectors, checked by the model only
    do_reset();
    for (int i = 0; i < NV; i++) begin
      bus.req = v_req[i]; bus.done = v_done[i];
      cyc(1);
    end
    bus.req = 4'b0000; bus.done = 1'b0;
    cyc(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
